filtr_mode_ctrl: RTL and testbench

FILTR_MODE_CTRL -- requirements
Module: filtr_mode_ctrl

---
 rtl/filtr_mode_ctrl_if.sv | 10 +
 rtl/filtr_mode_ctrl.sv | 110 +++++++++++
 tb/tb_filtr_mode_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/filtr_mode_ctrl_if.sv
// filtr_mode_ctrl_if: key/vsync inputs and mode outputs of the colour-swap mode controller
interface filtr_mode_ctrl_if;
    logic [1:0] iKEY;
    logic       iVS_N;
    logic [1:0] oButton;
    logic       oPending;
    logic       oMode_change;
    modport master (output iKEY, iVS_N, input oButton, oPending, oMode_change);
    modport slave (input iKEY, iVS_N, output oButton, oPending, oMode_change);
endinterface

// File: rtl/filtr_mode_ctrl.sv
// filtr_mode_ctrl: debounced pushbuttons select the colour-swap filter mode.
// FILTR_VSYNC_ALIGN_EN defers each mode change to the next vertical-sync falling edge.
module filtr_mode_ctrl #(
    parameter int DEB_MAX = 500000,
    parameter int DEB_W   = 20
) (
    input logic              iCLK,
    input logic              iRST_N,
    filtr_mode_ctrl_if.slave bus
);
    logic [1:0] keyS1, keyS2, deb, debD, evt;
    logic [DEB_W-1:0] cnt [2];
    logic [1:0] button, buttonNx, base, evtMode;
    logic modeChange, chg, anyEvt;

    function automatic logic [1:0] nextMode(input logic [1:0] m);
        return m == 2'b11 ? 2'b00 : m == 2'b00 ? 2'b10 : m == 2'b10 ? 2'b01 : 2'b11;
    endfunction

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            keyS1 <= 2'b11;
            keyS2 <= 2'b11;
            deb   <= 2'b11;
            debD  <= 2'b11;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            keyS1 <= bus.iKEY;
            keyS2 <= keyS1;
            debD  <= deb;
            for (int i = 0; i < 2; i++) begin
                if (keyS2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == DEB_W'(DEB_MAX - 1)) begin
                    cnt[i] <= '0;
                    deb[i] <= ~deb[i];
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // a press is the debounced 1->0 edge; releases are ignored
    assign evt     = debD & ~deb;
    assign anyEvt  = |evt;
    assign evtMode = evt[1] ? 2'b11 : nextMode(base);

`ifdef FILTR_VSYNC_ALIGN_EN
    typedef enum logic {IDLE, PENDING} state_t;
    state_t state, stateNx;
    logic [1:0] pendMode, pendNx;
    logic vsS1, vsS2, vsD, vsFall;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vsS1     <= 1'b1;
            vsS2     <= 1'b1;
            vsD      <= 1'b1;
            state    <= IDLE;
            pendMode <= 2'b11;
        end else begin
            vsS1     <= bus.iVS_N;
            vsS2     <= vsS1;
            vsD      <= vsS2;
            state    <= stateNx;
            pendMode <= pendNx;
        end
    end

    assign vsFall       = vsD & ~vsS2;
    assign base         = state == PENDING ? pendMode : button;
    assign bus.oPending = state == PENDING;

    // an event coinciding with the frame edge is applied at once
    always_comb begin
        stateNx  = state;
        pendNx   = pendMode;
        buttonNx = button;
        chg      = 1'b0;
        if (anyEvt && !vsFall) begin
            stateNx = PENDING;
            pendNx  = evtMode;
        end else if (anyEvt || (state == PENDING && vsFall)) begin
            stateNx  = IDLE;
            pendNx   = anyEvt ? evtMode : pendMode;
            buttonNx = anyEvt ? evtMode : pendMode;
            chg      = 1'b1;
        end
    end
`else
    assign base         = button;
    assign bus.oPending = 1'b0;

    always_comb begin
        buttonNx = anyEvt ? evtMode : button;
        chg      = anyEvt;
    end
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            button     <= 2'b11;
            modeChange <= 1'b0;
        end else begin
            button     <= buttonNx;
            modeChange <= chg;
        end
    end

    assign bus.oButton      = button;
    assign bus.oMode_change = modeChange;
endmodule

// File: tb/tb_filtr_mode_ctrl.sv
// tb_filtr_mode_ctrl: directed scoreboard bench for filtr_mode_ctrl with DEB_MAX = 4.
module tb_filtr_mode_ctrl;
`ifdef FILTR_VSYNC_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    typedef struct {
        logic [1:0] mode;
        int         cyc;
    } exp_t;

    logic iCLK = 1'b0;
    logic iRST_N = 1'b0;
    int cyc = 0;
    int compared = 0;
    int failed = 0;
    exp_t sbq[$];

    filtr_mode_ctrl_if bus();
    filtr_mode_ctrl #(.DEB_MAX(4), .DEB_W(3)) dut (.iCLK(iCLK), .iRST_N(iRST_N), .bus(bus));

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    // every mode-change pulse must match the next queued mode and cycle
    always @(negedge iCLK) begin
        if (bus.oMode_change === 1'b1) begin
            compared++;
            if (sbq.size() == 0) begin
                failed++;
                $display("FAIL unexpected_pulse: oButton=%b at cycle %0d, none expected", bus.oButton, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (bus.oButton !== e.mode || cyc != e.cyc) begin
                    failed++;
                    $display("FAIL mode_change: got %b @%0d, expected %b @%0d", bus.oButton, cyc, e.mode, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic press(input logic [1:0] mask, input logic [1:0] expMode, input bit chkRise);
        int n0;
        n0 = cyc;
        bus.iKEY = ~mask;
        if (!ALIGN) sbq.push_back('{expMode, n0 + 7});
        step(6);
        @(negedge iCLK);
        if (chkRise) chk("pending_before_rise", {3'b0, bus.oPending}, 4'h0);
        step(1);
        @(negedge iCLK);
        chk("pending_after_press", {3'b0, bus.oPending}, {3'b0, ALIGN});
        step(3);
        bus.iKEY = 2'b11;
        step(10);
    endtask

    task automatic vsync(input logic [1:0] expMode, input bit applies);
        if (ALIGN && applies) sbq.push_back('{expMode, cyc + 3});
        bus.iVS_N = 1'b0;
        step(6);
        bus.iVS_N = 1'b1;
        step(6);
        chk("pending_after_vsync", {3'b0, bus.oPending}, 4'h0);
    endtask

    initial begin
        bus.iKEY  = 2'b11;
        bus.iVS_N = 1'b1;
        step(2);
        chk("reset_button", {2'b0, bus.oButton}, 4'h3);
        chk("reset_pending", {3'b0, bus.oPending}, 4'h0);
        chk("reset_pulse", {3'b0, bus.oMode_change}, 4'h0);
        iRST_N = 1'b1;
        step(2);
        vsync(2'b11, 1'b0);
        vsync(2'b11, 1'b0);
        chk("idle_button", {2'b0, bus.oButton}, 4'h3);
        bus.iKEY = 2'b10;
        step(3);
        bus.iKEY = 2'b11;
        step(15);
        chk("glitch_pending", {3'b0, bus.oPending}, 4'h0);
        chk("glitch_button", {2'b0, bus.oButton}, 4'h3);
        press(2'b01, 2'b00, 1'b1);
        vsync(2'b00, 1'b1);
        chk("first_mode", {2'b0, bus.oButton}, 4'h0);
        press(2'b11, 2'b11, 1'b1);
        vsync(2'b11, 1'b1);
        chk("both_keys", {2'b0, bus.oButton}, 4'h3);
        press(2'b10, 2'b11, 1'b1);
        vsync(2'b11, 1'b1);
        press(2'b01, 2'b00, 1'b1);
        press(2'b01, 2'b10, 1'b0);
        press(2'b01, 2'b01, 1'b0);
        vsync(2'b01, 1'b1);
        chk("three_presses", {2'b0, bus.oButton}, 4'h1);
        press(2'b01, 2'b11, 1'b1);
        press(2'b01, 2'b00, 1'b0);
        iRST_N = 1'b0;
        #1;
        chk("midreset_button", {2'b0, bus.oButton}, 4'h3);
        chk("midreset_pending", {3'b0, bus.oPending}, 4'h0);
        chk("midreset_pulse", {3'b0, bus.oMode_change}, 4'h0);
        step(2);
        iRST_N = 1'b1;
        step(2);
        vsync(2'b11, 1'b0);
        chk("after_reset_button", {2'b0, bus.oButton}, 4'h3);
        step(4);
        chk("queue_drained", 4'(sbq.size()), 4'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
